muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer that sits beside the EX stage. It accepts MULT/MULTU/DIV/DIVU requests, runs a 32-iteration shift-add or shift-subtract datapath, and holds the pipeline through the shared stall request until the HI/LO result is ready. It also cancels cleanly on a pipeline flush.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the multi-cycle multiply/divide unit.
// Provides the operand width default, op and FSM encodings, counter width.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(
    input logic [1:0] o
  );
    return o[1];
  endfunction

  function automatic logic op_is_signed(
    input logic [1:0] o
  );
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add / restoring-divide iteration.
// Ports: acc (2W working pair), operand (multiplicand/divisor), is_div, acc_next.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Multiply: the add carry is kept so the right shift
  // brings it into the top bit of the product.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0])
      sum = sum + {1'b0, operand};
  end

  // Divide: the shifted remainder can need one extra bit
  // before the compare, so it is held at WIDTH+1.
  always_comb begin
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    ge     = rem_sh >= {1'b0, operand};
    diff   = rem_sh[WIDTH-1:0] - operand;
  end

  always_comb begin
    acc_next = '0;
    if (is_div) begin
      if (ge)
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0],
                    acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MULT/MULTU/DIV/DIVU sequencer beside EX, stalls until HI/LO ready.
// Ports: clk, rst (sync, low), start, annul, op, operand_1/2 -> stall_request, done, hi, lo, div_by_zero.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             stall_request,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state;
  state_e nxt;

  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [CW-1:0]      cnt;
  logic               res_sign;
  logic               dvd_sign;

  logic               is_div;
  logic               is_sgn;
  logic               div_zero;
  logic               take;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign is_div   = op_is_div(op_r);
  assign is_sgn   = op_is_signed(op_r);
  assign div_zero = is_div && (b_r == '0);
  assign take     = start && !annul;

  assign a_mag = (is_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
  assign b_mag = (is_sgn && b_r[WIDTH-1]) ? -b_r : b_r;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .operand (opnd_r),
    .is_div  (is_div),
    .acc_next(acc_nx)
  );

  // Sign flags are zero for unsigned ops, so the
  // fix-up is a pass-through there.
  always_comb begin
    prod_fix = res_sign ? -acc : acc;
    quo_fix  = res_sign ? -acc[WIDTH-1:0]
                        : acc[WIDTH-1:0];
    rem_fix  = dvd_sign ? -acc[2*WIDTH-1:WIDTH]
                        : acc[2*WIDTH-1:WIDTH];
    fix_hi   = is_div ? rem_fix
                      : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div ? quo_fix
                      : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = S_PREP;
      S_PREP: nxt = div_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt == LAST) nxt = S_FIX;
      S_FIX:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (annul)
      nxt = S_IDLE;
  end

  always_comb begin
    stall_request = 1'b0;
    done          = 1'b0;
    unique case (state)
      S_IDLE: stall_request = take;
      S_PREP,
      S_CALC,
      S_FIX:  stall_request = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Working registers and the visible HI/LO are kept
  // apart so an annulled op never disturbs HI/LO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      opnd_r      <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_sign    <= 1'b0;
      dvd_sign    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (!annul) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= operand_1;
            b_r  <= operand_2;
          end
        end
        S_PREP: begin
          res_sign <= is_sgn &
                      (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          dvd_sign <= is_sgn & a_r[WIDTH-1];
          // Lower half seeds with multiplier or dividend.
          opnd_r <= is_div ? b_mag : a_mag;
          acc    <= {{WIDTH{1'b0}},
                     is_div ? a_mag : b_mag};
          cnt    <= '0;
          if (div_zero) begin
            hi          <= a_r;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end
        end
        S_CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
